// File: rtl/id_char_if.sv
// Character-interface bundle between the identifier string transmitter and its environment.
// The master side is the transmitter. The slave side loads the string and consumes the characters.
interface id_char_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [7:0]    wr_char;
    logic          start;
    logic          rdy;
    logic [7:0]    char;
    logic          char_vld;
    logic          busy;
    logic          done;
    logic [AW:0]   len;
    logic          is_id;
    logic          ovf;

    modport master (
        input  wr_en, wr_char, start, rdy,
        output char, char_vld, busy, done, len, is_id, ovf
    );

    modport slave (
        output wr_en, wr_char, start, rdy,
        input  char, char_vld, busy, done, len, is_id, ovf
    );
endinterface

// File: rtl/id_char_tx.sv
// Buffers an ASCII string, replays it and then a separator over a valid/ready stream,
// and tracks whether the buffered string is a legal identifier.
module id_char_tx #(
    parameter int         DEPTH = 16,
    parameter int         AW    = 4,
    parameter logic [7:0] SEP   = 8'h20
) (
    input logic         clk,
    input logic         reset,
    id_char_if.master   bus
);
    typedef enum logic [1:0] {LOAD, SEND, SEPR, DONE} state_t;

    localparam logic [AW:0] FULL_LEN = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW + 1)'(1);

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [AW:0]   len_q;
    logic [AW-1:0] rd_ptr_q;
    logic          is_id_q;
    logic          ovf_q;

    logic          full;
    logic          wr_ok;
    logic          go;
    logic          last;
    logic [7:0]    char_d;
    logic          char_vld_d;
    logic          busy_d;
    logic          done_d;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    assign full  = (len_q == FULL_LEN);
    assign wr_ok = (state_q == LOAD) && bus.wr_en && !full;
    // A write in the same cycle as start counts, so the length test also accepts that write.
    assign go    = (state_q == LOAD) && bus.start && ((len_q != '0) || bus.wr_en);
    assign last  = ({1'b0, rd_ptr_q} == (len_q - ONE));

    // NOTE: the character buffer has no reset. Its contents only matter below len_q, and len_q is reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[len_q[AW-1:0]] <= bus.wr_char;
    end

    // NOTE: all sequential state uses non-blocking assignments. Every register then sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            len_q    <= '0;
            rd_ptr_q <= '0;
            is_id_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    if (bus.wr_en) begin
                        if (!full) begin
                            len_q   <= len_q + ONE;
                            is_id_q <= (len_q == '0) ? is_letter(bus.wr_char)
                                     : is_id_q & (is_letter(bus.wr_char) | is_digit(bus.wr_char));
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                    if (go) begin
                        rd_ptr_q <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
                SEND: if (bus.rdy && !last) rd_ptr_q <= rd_ptr_q + 1'b1;
                DONE: begin
                    len_q    <= '0;
                    is_id_q  <= 1'b0;
                    rd_ptr_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output gets a default before the case statement, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        char_d     = 8'h00;
        char_vld_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            LOAD: if (go) state_d = SEND;
            SEND: begin
                busy_d     = 1'b1;
                char_d     = mem[rd_ptr_q];
                char_vld_d = 1'b1;
                if (bus.rdy && last) state_d = SEPR;
            end
            SEPR: begin
                busy_d     = 1'b1;
                char_d     = SEP;
                char_vld_d = 1'b1;
                if (bus.rdy) state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    assign bus.char     = char_d;
    assign bus.char_vld = char_vld_d;
    assign bus.busy     = busy_d;
    assign bus.done     = done_d;
    assign bus.len      = len_q;
    assign bus.is_id    = is_id_q;
    assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_id_char_tx.sv
// Randomized and directed bench for id_char_tx. A string-level reference model
// supplies the expected stream, length, identifier flag and overflow flag.
module tb_id_char_tx;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mq[$];
    bit         movf;

    id_char_if #(.AW(AW)) bus ();

    id_char_tx #(.DEPTH(DEPTH), .AW(AW), .SEP(8'h20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit letter(input logic [7:0] c);
        return (c inside {[8'h61:8'h7a]}) || (c inside {[8'h41:8'h5a]});
    endfunction

    function automatic bit model_is_id();
        if (mq.size() == 0) return 1'b0;
        if (!letter(mq[0])) return 1'b0;
        for (int i = 1; i < mq.size(); i++)
            if (!(letter(mq[i]) || (mq[i] inside {[8'h30:8'h39]}))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic write_char(input logic [7:0] c);
        bus.wr_en   = 1'b1;
        bus.wr_char = c;
        step();
        bus.wr_en = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(c);
        else movf = 1'b1;
        check("wr_len", 32'(bus.len), 32'(mq.size()));
        check("wr_is_id", 32'(bus.is_id), 32'(model_is_id()));
        check("wr_ovf", 32'(bus.ovf), 32'(movf));
        check("wr_vld", 32'(bus.char_vld), 0);
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) write_char(s[i]);
    endtask

    // mode: 0 rdy always high, 1 rdy alternating 1/0, 2 rdy random
    task automatic send(input int mode, input bit add_x);
        logic [7:0] exp[$];
        int idx;
        int cyc;
        bit r;
        bus.start = 1'b1;
        if (add_x) begin
            bus.wr_en   = 1'b1;
            bus.wr_char = 8'h78;
        end
        step();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (add_x) mq.push_back(8'h78);
        movf = 1'b0;
        check("start_ovf", 32'(bus.ovf), 0);
        exp = mq;
        exp.push_back(8'h20);
        idx = 0;
        cyc = 0;
        while (idx < exp.size() && cyc < 400) begin
            check("tx_vld", 32'(bus.char_vld), 1);
            check("tx_char", 32'(bus.char), 32'(exp[idx]));
            check("tx_busy", 32'(bus.busy), 1);
            check("tx_done", 32'(bus.done), 0);
            check("tx_len", 32'(bus.len), 32'(mq.size()));
            check("tx_is_id", 32'(bus.is_id), 32'(model_is_id()));
            case (mode)
                0: r = 1'b1;
                1: r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.rdy = r;
            step();
            if (r) idx++;
            cyc++;
        end
        bus.rdy = 1'b0;
        if (idx < exp.size()) check("tx_timeout", 0, 1);
        check("done_pulse", 32'(bus.done), 1);
        check("done_vld", 32'(bus.char_vld), 0);
        check("done_char", 32'(bus.char), 0);
        step();
        mq.delete();
        check("post_len", 32'(bus.len), 0);
        check("post_is_id", 32'(bus.is_id), 0);
        check("post_done", 32'(bus.done), 0);
        check("post_busy", 32'(bus.busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        mq.delete();
        movf = 1'b0;
    endtask

    initial begin
        string cs;
        bus.wr_en   = 1'b0;
        bus.wr_char = 8'h00;
        bus.start   = 1'b0;
        bus.rdy     = 1'b0;
        do_reset();
        check("rst_len", 32'(bus.len), 0);
        check("rst_vld", 32'(bus.char_vld), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_is_id", 32'(bus.is_id), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        check("rst_char", 32'(bus.char), 0);

        load_str("abc012");
        send(0, 1'b0);

        load_str("2ab");
        send(0, 1'b0);

        load_str("ab%");
        send(1, 1'b0);

        load_str("ABCDEFGHIJKLMNOPQ");
        check("ovf_set", 32'(bus.ovf), 1);
        send(0, 1'b0);

        // Abort after two characters are accepted.
        load_str("abcd");
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.rdy   = 1'b1;
        step();
        step();
        bus.rdy = 1'b0;
        check("pre_abort_char", 32'(bus.char), 32'(8'h63));
        reset = 1'b1;
        step();
        reset = 1'b0;
        mq.delete();
        check("abort_vld", 32'(bus.char_vld), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_len", 32'(bus.len), 0);
        check("abort_is_id", 32'(bus.is_id), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_done", 32'(bus.done), 0);
        end

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("empty_start_busy", 32'(bus.busy), 0);
        check("empty_start_vld", 32'(bus.char_vld), 0);
        send(0, 1'b1);

        cs = "abcqXYZ0189_%$ ";
        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) write_char(cs[$urandom_range(0, cs.len() - 1)]);
            send(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)) && (n < DEPTH));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
